// File: rtl/mips_main_control.sv
// mips_main_control: multicycle MIPS main control FSM.
// Outputs are Moore decodes of the current state; FETCH also uses mem_ready_i
// so the PC and IR update only when the fetch read completes.
// A wait counter aborts stalled memory accesses after MEM_TIMEOUT wait cycles.
// Optional build macro: MIPS_BNE_EN adds a BNE execute state (opcode 000101).
module mips_main_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [1:0] ALUop_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] PCSrc_o,
  output logic       IorD_o,
  output logic       IRWrite_o,
  output logic       MemWrite_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       Branch_o,
  output logic       PCWrite_o,
  output logic       pcEn_o,
  output logic [3:0] state_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_BNEEX  = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MIPS_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  // Value of the wait counter during the last permitted wait cycle
  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_next_wait_cnt;
  logic       r_err;
  logic       w_next_err;
  logic       w_waiting;

  // Next-state, abort detection and wait counter update
  always_comb begin
    w_next_state    = r_state;
    w_next_err      = 1'b0;
    w_next_wait_cnt = 8'd0;
    w_waiting       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready_i) w_next_state = S_DECODE;
        else             w_waiting    = 1'b1;
      end
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RT:        w_next_state = S_RTEX;
          OP_BEQ:       w_next_state = S_BEQEX;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       w_next_state = S_BNEEX;
`endif
          default: begin
            w_next_state = S_FETCH;
            w_next_err   = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach here and the IR keeps opcode_i stable
      S_MEMADR: w_next_state = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready_i) w_next_state = S_MEMWB;
        else             w_waiting    = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready_i) w_next_state = S_FETCH;
        else             w_waiting    = 1'b1;
      end
      S_RTEX:   w_next_state = S_RTWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_MEMWB, S_RTWB, S_ADDIWB, S_BEQEX, S_JEX: w_next_state = S_FETCH;
`ifdef MIPS_BNE_EN
      S_BNEEX:  w_next_state = S_FETCH;
`endif
      // Unreachable encodings recover to FETCH and flag the event
      default: begin
        w_next_state = S_FETCH;
        w_next_err   = 1'b1;
      end
    endcase
    // Any non-wait cycle clears the count; a full wait window aborts
    if (w_waiting) begin
      if (r_wait_cnt == LP_WAIT_LAST) begin
        w_next_state    = S_FETCH;
        w_next_err      = 1'b1;
        w_next_wait_cnt = 8'd0;
      end else begin
        w_next_wait_cnt = r_wait_cnt + 8'd1;
      end
    end
  end

  // State, wait counter and error pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      r_err      <= w_next_err;
    end
  end

  // Moore output decode; anything not set for a state stays 0
  always_comb begin
    ALUop_o    = 2'b00;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    PCSrc_o    = 2'b00;
    IorD_o     = 1'b0;
    IRWrite_o  = 1'b0;
    MemWrite_o = 1'b0;
    RegWrite_o = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    Branch_o   = 1'b0;
    PCWrite_o  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      S_DECODE: ALUSrcB_o = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_MEMRD: IorD_o = 1'b1;
      S_MEMWR: begin
        IorD_o     = 1'b1;
        MemWrite_o = 1'b1;
      end
      S_MEMWB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_RTEX: begin
        ALUSrcA_o = 1'b1;
        ALUop_o   = 2'b10;
      end
      S_RTWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      S_ADDIWB: RegWrite_o = 1'b1;
      S_BEQEX: begin
        ALUSrcA_o = 1'b1;
        ALUop_o   = 2'b01;
        PCSrc_o   = 2'b01;
        Branch_o  = 1'b1;
      end
`ifdef MIPS_BNE_EN
      S_BNEEX: begin
        ALUSrcA_o = 1'b1;
        ALUop_o   = 2'b01;
        PCSrc_o   = 2'b01;
        Branch_o  = 1'b1;
      end
`endif
      S_JEX: begin
        PCSrc_o   = 2'b10;
        PCWrite_o = 1'b1;
      end
      default: ;
    endcase
  end

  // In BNEEX the branch is taken on ~zero only; the zero term is for BEQ
`ifdef MIPS_BNE_EN
  logic w_in_bne;
  assign w_in_bne = (r_state == S_BNEEX);
  assign pcEn_o   = PCWrite_o | (Branch_o & zero_i & ~w_in_bne)
                  | (Branch_o & ~zero_i & w_in_bne);
`else
  assign pcEn_o   = PCWrite_o | (Branch_o & zero_i);
`endif

  assign state_o = r_state;
  assign err_o   = r_err;

endmodule
